bundle_dispatch: RTL
====================

# bundle_dispatch

Downstream consumer of the 256-bit instruction bundle queue. Pops one bundle at a time, splits it into eight 32-bit instruction slots and issues them in order to the two superscalar decode lanes, two per cycle (one per cycle in single-issue builds). Handles the queue's one-cycle read latency, back-pressure from decode, and pipeline flush.

## Interface
Parameters: none.

Ports:
- Clock and reset: `clk` drives the block. Reset is `rst`, asynchronous, active-low.
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous active-low reset
- `q_empty`  in  1  queue holds no bundle
- `q_rd_ok`  in  1  queue honours a read this cycle (low when the queue is taking a write)
- `q_data`  in  256  queue read data; valid the cycle after an accepted read
- `q_read`  out  1  read strobe to queue (combinational)
- `stall`  in  1  decode cannot accept; hold issue outputs
- `flush`  in  1  discard current bundle and any in-flight read
- `iss0_valid`  out  1  lane 0 instruction valid
- `iss0_instr`  out  32  lane 0 instruction
- `iss1_valid`  out  1  lane 1 instruction valid
- `iss1_instr`  out  32  lane 1 instruction
- `instr_count`  out  32  total instructions issued since reset, wraps modulo 2^32

## Operation
- Slot k of a bundle is `q_data[32k+31:32k]`, k=0..7. Issue order is slot 0 first. All slots issue, including 32'h0 (NOP).
- States: IDLE, LOAD, ISSUE. Internal: 256-bit `bundle_q`, 3-bit slot index `idx`.
- `q_read = rst & (state==IDLE) & !q_empty & !flush`.
- IDLE: if `q_read & q_rd_ok`, go to LOAD. If `q_read & !q_rd_ok`, stay in IDLE and retry next cycle.
- LOAD: `bundle_q <= q_data`, `idx <= 0`, go to ISSUE.
- ISSUE when `!stall`:
  - Lane 0 gets slot `idx`. Lane 1 gets slot `idx+1`. Both valid.
  - `idx += 2`.
  - `instr_count += 2`.
  - If `idx==6`, go to IDLE.
- ISSUE when `stall`: `idx`, state and all issue outputs hold.
- Outside ISSUE:
  - `stall=0`: the valids clear at the clock edge and the instr outputs hold their last value.
  - `stall=1`: all issue outputs hold.
- Flush has the highest priority and overrides stall. At the edge:
  - state goes to IDLE, `idx` goes to 0, both valids clear.
  - `bundle_q` is don't-care.
  - Flush in LOAD discards that cycle's `q_data`.
  - `instr_count` is unaffected.
- Reset sets:
  - state to IDLE, `idx` and `bundle_q` to 0.
  - valids to 0, instrs to 32'h0, `instr_count` to 0.
  - `q_read` forced to 0 while `rst` is low.
  - Reset mid-bundle abandons the bundle.

## Timing
- Cycle A: IDLE with `q_read=1` and `q_rd_ok=1`. Cycle A+1: LOAD with `q_data` valid. Cycle A+2: ISSUE for the first pair.
- First instructions are visible at A+3. Latency is 3 cycles from `q_read` to the first valid output.
- Without stall, a dual-issue bundle occupies ISSUE for 4 cycles. Minimum bundle period is 6 cycles (IDLE, LOAD, 4×ISSUE). There is no prefetch overlap.
- All issue outputs and `instr_count` are registered. `q_read` is the only combinational output.
- `q_empty` is sampled only in IDLE. Its value in LOAD and ISSUE is ignored.

## Configuration
- Macro: `BUNDLE_DISPATCH_DUAL_ISSUE_EN`.
- Defined: dual issue as above.
- Undefined (single issue):
  - `iss1_valid` is held at 0 and `iss1_instr` at 32'h0.
  - Lane 0 takes slot `idx` each ISSUE cycle.
  - `idx += 1` and `instr_count += 1`.
  - Exit to IDLE when `idx==7`.
  - A bundle takes 8 ISSUE cycles. Minimum period is 10 cycles.

## Test plan
- Reset, then `q_empty=0`, `q_rd_ok=1`, bundle slots = 32'h1000_0000+k:
  - `q_read` pulses for 1 cycle.
  - Pairs (…00, …01), (…02, …03), (…04, …05), (…06, …07) appear on 4 consecutive cycles starting 3 cycles after `q_read`.
  - `instr_count` reaches 8.
- `q_rd_ok=0` for 3 cycles while `q_empty=0`: `q_read` stays high those 3 cycles, state remains IDLE, and LOAD follows the first cycle with `q_rd_ok=1`.
- `stall=1` for 5 cycles after the first pair: outputs hold (…00, …01), both valids stay 1, then the sequence resumes at (…02, …03). No slot is skipped or duplicated.
- Flush in LOAD, and flush in ISSUE after the second pair:
  - Valids clear the next cycle and state is IDLE.
  - `instr_count` stays at 0 (LOAD case) and 4 (ISSUE case).
  - The next bundle issues from slot 0.
- Flush together with `stall=1`: flush wins and valids clear.
- Assert `rst` low mid-ISSUE: all outputs go to 0 immediately and `q_read=0`. After release with `q_empty=1`, the block stays idle.
- Single-issue build: the same bundle issues …00 … …07 on lane 0 over 8 cycles, `iss1_valid` stays 0, and `instr_count` = 8.

Source files
------------

// File: rtl/bundle_dispatch.sv
// bundle_dispatch: splits 256-bit queue bundles into 32-bit slots issued in order to decode.
// Define BUNDLE_DISPATCH_DUAL_ISSUE_EN for two slots per cycle; otherwise single issue on lane 0.
module bundle_dispatch (
  input  logic         clk,
  input  logic         rst,
  input  logic         q_empty,
  input  logic         q_rd_ok,
  input  logic [255:0] q_data,
  output logic         q_read,
  input  logic         stall,
  input  logic         flush,
  output logic         iss0_valid,
  output logic [31:0]  iss0_instr,
  output logic         iss1_valid,
  output logic [31:0]  iss1_instr,
  output logic [31:0]  instr_count
);
`ifdef BUNDLE_DISPATCH_DUAL_ISSUE_EN
  localparam logic [2:0] STEP = 3'd2;
  localparam logic [2:0] LAST = 3'd6;
`else
  localparam logic [2:0] STEP = 3'd1;
  localparam logic [2:0] LAST = 3'd7;
`endif
  typedef enum logic [1:0] {IDLE, LOAD, ISSUE} state_t;
  state_t       state;
  logic [255:0] bundle_q;
  logic [2:0]   idx;
  assign q_read = rst & (state == IDLE) & ~q_empty & ~flush;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      bundle_q    <= '0;
      iss0_valid  <= 1'b0;
      iss1_valid  <= 1'b0;
      iss0_instr  <= '0;
      iss1_instr  <= '0;
      instr_count <= '0;
    end else if (flush) begin
      state      <= IDLE;
      idx        <= '0;
      iss0_valid <= 1'b0;
      iss1_valid <= 1'b0;
    end else if (state == ISSUE) begin
      if (!stall) begin
        iss0_valid  <= 1'b1;
        iss0_instr  <= bundle_q[{idx, 5'd0} +: 32];
`ifdef BUNDLE_DISPATCH_DUAL_ISSUE_EN
        iss1_valid  <= 1'b1;
        iss1_instr  <= bundle_q[{idx + 3'd1, 5'd0} +: 32];
`endif
        idx         <= idx + STEP;
        instr_count <= instr_count + {29'd0, STEP};
        if (idx == LAST) state <= IDLE;
      end
    end else begin
      if (!stall) begin
        iss0_valid <= 1'b0;
        iss1_valid <= 1'b0;
      end
      // q_read already implies IDLE, so an unreachable encoding also falls back to IDLE
      if (state == LOAD) begin
        bundle_q <= q_data;
        idx      <= '0;
        state    <= ISSUE;
      end else
        state <= (q_read && q_rd_ok) ? LOAD : IDLE;
    end
endmodule
